// File: rtl/gate_sequencer_if.sv
// Sensor, password and status bundle between the gate sequencer and its environment.
interface gate_if;
    logic       entry_sensor;
    logic       exit_sensor;
    logic       pass_valid;
    logic [3:0] pass_code;
    logic       gate_open;
    logic       alarm;
    logic [2:0] state;
    logic [3:0] occupancy;
    logic       full;
    logic [9:0] timer_val;

    modport master (
        output entry_sensor, exit_sensor, pass_valid, pass_code,
        input  gate_open, alarm, state, occupancy, full, timer_val
    );
    modport slave (
        input  entry_sensor, exit_sensor, pass_valid, pass_code,
        output gate_open, alarm, state, occupancy, full, timer_val
    );
endinterface

// File: rtl/gate_sequencer.sv
// Parking gate controller: password-gated entry, timed gate opening, retry lockout
// and an occupancy count that blocks entry when the lot is full.
module gate_sequencer #(
    parameter logic [3:0] PASSWORD     = 4'hA,
    parameter int         PASS_TIMEOUT = 999,
    parameter int         OPEN_TIME    = 500,
    parameter int         MAX_RETRIES  = 3,
    parameter int         LOCK_TIME    = 1000,
    parameter int         CAPACITY     = 8
) (
    input  logic clk,
    input  logic reset,
    gate_if.slave gif
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WAIT_PASS  = 3'd1;
    localparam logic [2:0] ENTRY_OPEN = 3'd2;
    localparam logic [2:0] EXIT_OPEN  = 3'd3;
    localparam logic [2:0] WRONG      = 3'd4;
    localparam logic [2:0] LOCKOUT    = 3'd5;

    // A timed state ends on the cycle its timer shows duration-1.
    localparam logic [9:0] PASS_LAST = 10'(PASS_TIMEOUT - 1);
    localparam logic [9:0] OPEN_LAST = 10'(OPEN_TIME - 1);
    localparam logic [9:0] LOCK_LAST = 10'(LOCK_TIME - 1);
    localparam logic [3:0] CAP       = 4'(CAPACITY);
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRIES);

    logic [2:0] state_q, state_d;
    logic [9:0] timer_q, timer_d;
    logic [2:0] retry_q, retry_d;
    logic [3:0] occ_q, occ_d;
    logic       gate_q, gate_d;
    logic       alarm_q, alarm_d;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        occ_d   = occ_q;
        case (state_q)
            IDLE: begin
                if (gif.exit_sensor && occ_q != 4'd0)
                    state_d = EXIT_OPEN;
                else if (gif.entry_sensor && occ_q != CAP)
                    state_d = WAIT_PASS;
            end
            WAIT_PASS: begin
                if (gif.pass_valid) begin
                    if (gif.pass_code == PASSWORD) begin
                        state_d = ENTRY_OPEN;
                        retry_d = 3'd0;
                    end else begin
                        state_d = WRONG;
                        retry_d = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;
                    end
                end else if (timer_q == PASS_LAST) begin
                    state_d = IDLE;
                    retry_d = 3'd0;
                end
            end
            ENTRY_OPEN: begin
                if (timer_q == OPEN_LAST) begin
                    state_d = IDLE;
                    if (occ_q != CAP) occ_d = occ_q + 4'd1;
                end
            end
            EXIT_OPEN: begin
                if (timer_q == OPEN_LAST) begin
                    state_d = IDLE;
                    if (occ_q != 4'd0) occ_d = occ_q - 4'd1;
                end
            end
            WRONG:   state_d = (retry_q == RETRY_MAX) ? LOCKOUT : WAIT_PASS;
            LOCKOUT: begin
                if (timer_q == LOCK_LAST) begin
                    state_d = IDLE;
                    retry_d = 3'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Any state change (including WRONG back to WAIT_PASS) restarts the timer.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q || state_d == IDLE || state_d == WRONG)
            timer_d = 10'd0;
        else if (timer_q != 10'h3FF)
            timer_d = timer_q + 10'd1;
    end

    // Outputs are decoded from the next state so the registers track state_q exactly.
    always_comb begin
        gate_d  = (state_d == ENTRY_OPEN) || (state_d == EXIT_OPEN);
        alarm_d = (state_d == WRONG) || (state_d == LOCKOUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= 10'd0;
            retry_q <= 3'd0;
            occ_q   <= 4'd0;
            gate_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            occ_q   <= occ_d;
            gate_q  <= gate_d;
            alarm_q <= alarm_d;
        end
    end

    assign gif.state     = state_q;
    assign gif.timer_val = timer_q;
    assign gif.occupancy = occ_q;
    assign gif.full      = (occ_q == CAP);
    assign gif.gate_open = gate_q;
    assign gif.alarm     = alarm_q;
endmodule

// File: tb/tb_gate_sequencer.sv
// Bench for gate_sequencer: a scripted entry table, corner-case sequences and a
// randomized run, all checked against a cycle-count model of the gate rules.
module tb_gate_sequencer;
    localparam int PT = 10, OT = 4, MR = 2, LT = 6, CAP = 2, PW = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gate_if gif ();
    gate_sequencer #(
        .PASSWORD(4'hA), .PASS_TIMEOUT(PT), .OPEN_TIME(OT),
        .MAX_RETRIES(MR), .LOCK_TIME(LT), .CAPACITY(CAP)
    ) dut (.clk(clk), .reset(reset), .gif(gif));

    int total = 0;
    int bad   = 0;

    // Model: named phase, cycles spent in it, wrong attempts so far, cars parked.
    typedef enum int {M_IDLE = 0, M_WAIT = 1, M_ENTRY = 2, M_EXIT = 3, M_WRONG = 4, M_LOCK = 5} phase_t;
    phase_t ph;
    int spent, tries, cars;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dur(input phase_t p);
        case (p)
            M_WAIT:          return PT;
            M_ENTRY, M_EXIT: return OT;
            M_LOCK:          return LT;
            default:         return 1;
        endcase
    endfunction

    task automatic model_reset();
        ph = M_IDLE; spent = 0; tries = 0; cars = 0;
    endtask

    task automatic model_step(input bit en, input bit ex, input bit pv, input int code);
        phase_t nx;
        bool_last: begin end
        nx = ph;
        case (ph)
            M_IDLE:
                if (ex && cars > 0) nx = M_EXIT;
                else if (en && cars < CAP) nx = M_WAIT;
            M_WAIT:
                if (pv) begin
                    if (code == PW) begin nx = M_ENTRY; tries = 0; end
                    else begin nx = M_WRONG; tries = (tries < 7) ? tries + 1 : 7; end
                end else if (spent + 1 == dur(ph)) begin
                    nx = M_IDLE; tries = 0;
                end
            M_ENTRY:
                if (spent + 1 == dur(ph)) begin nx = M_IDLE; cars = (cars < CAP) ? cars + 1 : CAP; end
            M_EXIT:
                if (spent + 1 == dur(ph)) begin nx = M_IDLE; cars = (cars > 0) ? cars - 1 : 0; end
            M_WRONG:
                nx = (tries == MR) ? M_LOCK : M_WAIT;
            M_LOCK:
                if (spent + 1 == dur(ph)) begin nx = M_IDLE; tries = 0; end
            default: nx = M_IDLE;
        endcase
        spent = (nx != ph) ? 0 : spent + 1;
        ph = nx;
    endtask

    task automatic check_model(input string tag);
        int exp_t;
        exp_t = (ph == M_IDLE || ph == M_WRONG) ? 0 : ((spent > 1023) ? 1023 : spent);
        chk({tag, ".state"}, int'(gif.state), int'(ph));
        chk({tag, ".timer"}, int'(gif.timer_val), exp_t);
        chk({tag, ".gate"}, int'(gif.gate_open), int'(ph == M_ENTRY || ph == M_EXIT));
        chk({tag, ".alarm"}, int'(gif.alarm), int'(ph == M_WRONG || ph == M_LOCK));
        chk({tag, ".occ"}, int'(gif.occupancy), cars);
        chk({tag, ".full"}, int'(gif.full), int'(cars == CAP));
    endtask

    task automatic cyc(input string tag, input bit en, input bit ex, input bit pv, input logic [3:0] code);
        gif.entry_sensor = en;
        gif.exit_sensor  = ex;
        gif.pass_valid   = pv;
        gif.pass_code    = code;
        @(posedge clk);
        model_step(en, ex, pv, int'(code));
        #1;
        check_model(tag);
    endtask

    task automatic enter_car(input string tag);
        cyc(tag, 1, 0, 0, 4'h0);
        cyc(tag, 0, 0, 1, 4'hA);
        for (int i = 0; i < OT; i++) cyc(tag, 0, 0, 0, 4'h0);
    endtask

    typedef struct {
        bit en, ex, pv;
        logic [3:0] code;
        int st, tm, gate, occ;
    } vec_t;
    vec_t tv[9];

    initial begin
        int n_wp, n_gate, n_lock, n_alarm;
        // Entry: password on the fourth WAIT_PASS cycle, gate open four cycles.
        tv[0] = '{1, 0, 0, 4'h0, 1, 0, 0, 0};
        tv[1] = '{0, 0, 0, 4'h0, 1, 1, 0, 0};
        tv[2] = '{0, 0, 1, 4'hA, 1, 2, 0, 0};  // pass_valid wrongly low? no: see below
        tv[2].pv = 0;
        tv[3] = '{0, 0, 0, 4'h0, 1, 3, 0, 0};
        tv[4] = '{0, 0, 1, 4'hA, 2, 0, 1, 0};
        tv[5] = '{1, 1, 1, 4'hA, 2, 1, 1, 0};  // sensors and strobe ignored while open
        tv[6] = '{0, 0, 0, 4'h0, 2, 2, 1, 0};
        tv[7] = '{0, 0, 0, 4'h0, 2, 3, 1, 0};
        tv[8] = '{0, 0, 0, 4'h0, 0, 0, 0, 1};

        reset = 1'b1;
        gif.entry_sensor = 0; gif.exit_sensor = 0; gif.pass_valid = 0; gif.pass_code = 4'h0;
        model_reset();
        @(posedge clk); #1;
        check_model("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            cyc("tbl", tv[i].en, tv[i].ex, tv[i].pv, tv[i].code);
            chk($sformatf("tbl%0d.state", i), int'(gif.state), tv[i].st);
            chk($sformatf("tbl%0d.timer", i), int'(gif.timer_val), tv[i].tm);
            chk($sformatf("tbl%0d.gate", i), int'(gif.gate_open), tv[i].gate);
            chk($sformatf("tbl%0d.occ", i), int'(gif.occupancy), tv[i].occ);
        end

        // Timeout: ten WAIT_PASS cycles, then IDLE, no gate.
        n_wp = 0; n_gate = 0;
        cyc("tmo", 1, 0, 0, 4'h0);
        if (gif.state == 3'd1) n_wp++;
        for (int i = 0; i < PT; i++) begin
            cyc("tmo", 0, 0, 0, 4'h0);
            if (gif.state == 3'd1) n_wp++;
            if (gif.gate_open) n_gate++;
        end
        chk("tmo.len", n_wp, PT);
        chk("tmo.gate", n_gate, 0);
        chk("tmo.state", int'(gif.state), 0);
        chk("tmo.occ", int'(gif.occupancy), 1);

        // Lockout after two wrong codes; a correct code during lockout is ignored.
        n_lock = 0; n_alarm = 0;
        cyc("lck", 1, 0, 0, 4'h0);
        cyc("lck", 0, 0, 1, 4'h3);
        chk("lck.wrong1", int'(gif.state), 4);
        cyc("lck", 0, 0, 0, 4'h0);
        chk("lck.back", int'(gif.state), 1);
        cyc("lck", 0, 0, 1, 4'h5);
        chk("lck.wrong2", int'(gif.state), 4);
        for (int i = 0; i < LT + 1; i++) begin
            cyc("lck", 0, 0, 1, 4'hA);
            if (gif.state == 3'd5) n_lock++;
            if (gif.alarm) n_alarm++;
        end
        chk("lck.len", n_lock, LT);
        chk("lck.alarm", n_alarm, LT);
        chk("lck.state", int'(gif.state), 0);

        // Full lot blocks entry; exit wins when both sensors are active.
        enter_car("ful");
        chk("ful.occ", int'(gif.occupancy), 2);
        chk("ful.full", int'(gif.full), 1);
        cyc("ful", 1, 0, 0, 4'h0);
        chk("ful.block", int'(gif.state), 0);
        cyc("ful", 1, 1, 0, 4'h0);
        chk("ful.exit", int'(gif.state), 3);
        for (int i = 0; i < OT; i++) cyc("ful", 0, 0, 0, 4'h0);
        chk("ful.occ1", int'(gif.occupancy), 1);
        chk("ful.full0", int'(gif.full), 0);

        // Asynchronous reset on the second ENTRY_OPEN cycle.
        cyc("rst", 1, 0, 0, 4'h0);
        cyc("rst", 0, 0, 1, 4'hA);
        cyc("rst", 0, 0, 0, 4'h0);
        chk("rst.pre", int'(gif.gate_open), 1);
        #2 reset = 1'b1;
        #1;
        chk("rst.gate", int'(gif.gate_open), 0);
        chk("rst.state", int'(gif.state), 0);
        chk("rst.occ", int'(gif.occupancy), 0);
        chk("rst.timer", int'(gif.timer_val), 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        check_model("rst.after");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) begin
                reset = 1'b1;
                @(posedge clk);
                model_reset();
                #1;
                check_model("rnd.rst");
                reset = 1'b0;
            end else begin
                cyc("rnd", ($urandom_range(2) == 0), ($urandom_range(4) == 0),
                    ($urandom_range(3) == 0),
                    ($urandom_range(1) == 0) ? 4'hA : 4'($urandom_range(15)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
